// File: rtl/mss_u_sb_rst_pkg.sv
// Shared definitions for the CCC lock / fabric reset controller:
// FSM state encoding and the lock-loss event counter format.
package mss_u_sb_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        DEBOUNCE  = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } rst_state_e;

    localparam int              LOSS_W   = 8;
    localparam logic [LOSS_W-1:0] LOSS_SAT = {LOSS_W{1'b1}};

    // Increment that sticks at the saturation value instead of wrapping.
    function automatic logic [LOSS_W-1:0] loss_sat_inc(input logic [LOSS_W-1:0] v);
        return (v == LOSS_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mss_u_sb_sync_ff.sv
// N-stage synchronizer for a single asynchronous bit, cleared to 0 by the
// asynchronous active-low reset.
module mss_u_sb_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mss_u_sb_ccc_lock_rst_ctrl.sv
// Fabric reset controller downstream of the MSS_U_sb CCC. Debounces PLL LOCK,
// holds the fabric in reset for a fixed time after stable lock, and tracks
// loss-of-lock events (sticky flag plus saturating counter).
module mss_u_sb_ccc_lock_rst_ctrl
    import mss_u_sb_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int LOCK_DEBOUNCE = 1024,
    parameter int RESET_HOLD    = 16,
    parameter int LOSS_FILTER   = 4,
    parameter int CNT_W         = 16
) (
    input  logic              CLK_BASE,
    input  logic              RESET_N,
    input  logic              CCC_LOCK,
    input  logic              SOFT_RESET_N,
    input  logic              CLR_STICKY,
    output logic              FABRIC_RESET_N,
    output logic              LOCK_STABLE,
    output logic              LOCK_LOST,
    output logic [LOSS_W-1:0] LOSS_COUNT
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(LOCK_DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);

    logic              w_lock_s;
    logic              w_srst_s;
    rst_state_e        r_state;
    rst_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_stable;
    logic              w_stable_nxt;
    logic              w_loss;
    logic              r_frn;
    logic              r_lost;
    logic [LOSS_W-1:0] r_loss_cnt;

    mss_u_sb_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .i_clk   (CLK_BASE),
        .i_rst_n (RESET_N),
        .i_d     (CCC_LOCK),
        .o_q     (w_lock_s)
    );

    mss_u_sb_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_srst (
        .i_clk   (CLK_BASE),
        .i_rst_n (RESET_N),
        .i_d     (SOFT_RESET_N),
        .o_q     (w_srst_s)
    );

    // Next state: lock rules first, then soft reset, then the shared counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_loss       = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (w_lock_s) w_state_nxt = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt  = HOLD;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt  = WAIT_LOCK;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = 1'b0;
                end else if (!w_srst_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                // cnt holds the length of the current run of lock_s=0 cycles
                if (!w_lock_s) begin
                    if (r_cnt == LOSS_LAST) begin
                        w_state_nxt  = WAIT_LOCK;
                        w_cnt_nxt    = '0;
                        w_stable_nxt = 1'b0;
                        w_loss       = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (!w_srst_s) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; the loss flag wins over a clear.
    always_ff @(posedge CLK_BASE or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_frn      <= 1'b0;
            r_lost     <= 1'b0;
            r_loss_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_frn    <= (w_state_nxt == RUN);
            if (w_loss) begin
                r_lost     <= 1'b1;
                r_loss_cnt <= loss_sat_inc(r_loss_cnt);
            end else if (CLR_STICKY) begin
                r_lost <= 1'b0;
            end
        end
    end

    assign FABRIC_RESET_N = r_frn;
    assign LOCK_STABLE    = r_stable;
    assign LOCK_LOST      = r_lost;
    assign LOSS_COUNT     = r_loss_cnt;

endmodule

// File: tb/tb_mss_u_sb_ccc_lock_rst_ctrl.sv
// Bench for the CCC lock / fabric reset controller: directed scenarios with
// literal expectations plus randomized lock/soft-reset traffic, all compared
// every cycle against a behavioural model.
module tb_mss_u_sb_ccc_lock_rst_ctrl;

    localparam int SS = 2;
    localparam int LD = 8;
    localparam int RH = 4;
    localparam int LF = 4;

    logic       CLK_BASE;
    logic       RESET_N;
    logic       CCC_LOCK;
    logic       SOFT_RESET_N;
    logic       CLR_STICKY;
    logic       FABRIC_RESET_N;
    logic       LOCK_STABLE;
    logic       LOCK_LOST;
    logic [7:0] LOSS_COUNT;

    int n_chk;
    int n_fail;

    // model: synchronizer histories and a phase/counter view of the controller
    localparam int P_WAIT = 0, P_DEB = 1, P_HOLD = 2, P_RUN = 3;
    bit lk_hist[SS];
    bit sr_hist[SS];
    int m_ph;
    int m_age;      // cycles spent in the current phase condition
    int m_stable;
    int m_lost;
    int m_losses;
    int m_frn;

    mss_u_sb_ccc_lock_rst_ctrl #(
        .SYNC_STAGES  (SS),
        .LOCK_DEBOUNCE(LD),
        .RESET_HOLD   (RH),
        .LOSS_FILTER  (LF),
        .CNT_W        (16)
    ) dut (
        .CLK_BASE      (CLK_BASE),
        .RESET_N       (RESET_N),
        .CCC_LOCK      (CCC_LOCK),
        .SOFT_RESET_N  (SOFT_RESET_N),
        .CLR_STICKY    (CLR_STICKY),
        .FABRIC_RESET_N(FABRIC_RESET_N),
        .LOCK_STABLE   (LOCK_STABLE),
        .LOCK_LOST     (LOCK_LOST),
        .LOSS_COUNT    (LOSS_COUNT)
    );

    initial CLK_BASE = 1'b0;
    always #5 CLK_BASE = ~CLK_BASE;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) begin
            lk_hist[i] = 1'b0;
            sr_hist[i] = 1'b0;
        end
        m_ph = P_WAIT; m_age = 0; m_stable = 0; m_lost = 0; m_losses = 0; m_frn = 0;
    endtask

    // One clock edge of the reference behaviour, using inputs present at the edge.
    task automatic model_step();
        bit ls, ss;
        bit loss;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        ls   = lk_hist[SS-1];
        ss   = sr_hist[SS-1];
        loss = 1'b0;
        if (m_ph == P_WAIT) begin
            m_age = 0;
            if (ls) m_ph = P_DEB;
        end else if (m_ph == P_DEB) begin
            if (!ls) begin m_ph = P_WAIT; m_age = 0; end
            else if (m_age + 1 == LD) begin m_ph = P_HOLD; m_age = 0; m_stable = 1; end
            else m_age++;
        end else if (m_ph == P_HOLD) begin
            if (!ls) begin m_ph = P_WAIT; m_age = 0; m_stable = 0; end
            else if (!ss) m_age = 0;
            else if (m_age + 1 == RH) begin m_ph = P_RUN; m_age = 0; end
            else m_age++;
        end else begin
            if (!ls) begin
                m_age++;
                if (m_age == LF) begin m_ph = P_WAIT; m_age = 0; m_stable = 0; loss = 1'b1; end
            end else if (!ss) begin
                m_ph = P_HOLD; m_age = 0;
            end else begin
                m_age = 0;
            end
        end
        if (loss) begin
            m_lost = 1;
            if (m_losses < 255) m_losses++;
        end else if (CLR_STICKY) begin
            m_lost = 0;
        end
        m_frn = (m_ph == P_RUN) ? 1 : 0;
        for (int i = SS - 1; i > 0; i--) begin
            lk_hist[i] = lk_hist[i-1];
            sr_hist[i] = sr_hist[i-1];
        end
        lk_hist[0] = CCC_LOCK;
        sr_hist[0] = SOFT_RESET_N;
    endtask

    task automatic compare_all();
        chk("FABRIC_RESET_N", int'(FABRIC_RESET_N), m_frn);
        chk("LOCK_STABLE", int'(LOCK_STABLE), m_stable);
        chk("LOCK_LOST", int'(LOCK_LOST), m_lost);
        chk("LOSS_COUNT", int'(LOSS_COUNT), m_losses);
    endtask

    // Advance one clock: model on the rising edge, compare on the falling edge.
    task automatic cyc();
        @(posedge CLK_BASE);
        model_step();
        @(negedge CLK_BASE);
        compare_all();
    endtask

    task automatic wait_frn(input int max, output int n);
        n = -1;
        for (int e = 1; e <= max; e++) begin
            cyc();
            if (FABRIC_RESET_N === 1'b1) begin
                n = e;
                break;
            end
        end
    endtask

    task automatic do_reset(input int n);
        RESET_N = 1'b0;
        model_reset();
        repeat (n) cyc();
        RESET_N = 1'b1;
    endtask

    initial begin
        int n;
        int st_edge;
        int fr_edge;
        int len;
        n_chk = 0;
        n_fail = 0;
        RESET_N = 1'b0;
        CCC_LOCK = 1'b0;
        SOFT_RESET_N = 1'b1;
        CLR_STICKY = 1'b0;
        model_reset();

        // Power-up release timing
        do_reset(5);
        chk("reset_frn", int'(FABRIC_RESET_N), 0);
        chk("reset_stable", int'(LOCK_STABLE), 0);
        chk("reset_lost", int'(LOCK_LOST), 0);
        chk("reset_count", int'(LOSS_COUNT), 0);
        CCC_LOCK = 1'b1;
        st_edge = -1;
        fr_edge = -1;
        for (int e = 1; e <= 40; e++) begin
            cyc();
            if (LOCK_STABLE === 1'b1 && st_edge < 0) st_edge = e;
            if (FABRIC_RESET_N === 1'b1) begin fr_edge = e; break; end
        end
        chk("pwrup_stable_edge", st_edge, 11);
        chk("pwrup_frn_edge", fr_edge, 15);

        // Debounce abort
        do_reset(3);
        CCC_LOCK = 1'b1;
        repeat (5) cyc();
        CCC_LOCK = 1'b0;
        cyc();
        CCC_LOCK = 1'b1;
        wait_frn(40, n);
        chk("abort_frn_edge", n, 15);
        chk("abort_lost", int'(LOCK_LOST), 0);

        // Short glitch ignored, long drop is a loss
        CCC_LOCK = 1'b0;
        repeat (3) cyc();
        CCC_LOCK = 1'b1;
        repeat (6) cyc();
        chk("glitch_frn", int'(FABRIC_RESET_N), 1);
        chk("glitch_lost", int'(LOCK_LOST), 0);
        CCC_LOCK = 1'b0;
        repeat (6) cyc();
        chk("loss_frn", int'(FABRIC_RESET_N), 0);
        chk("loss_stable", int'(LOCK_STABLE), 0);
        chk("loss_lost", int'(LOCK_LOST), 1);
        chk("loss_count", int'(LOSS_COUNT), 1);
        CCC_LOCK = 1'b1;
        wait_frn(40, n);
        chk("relock_frn_edge", n, 15);

        // Soft reset in RUN
        SOFT_RESET_N = 1'b0;
        repeat (10) cyc();
        chk("soft_frn", int'(FABRIC_RESET_N), 0);
        chk("soft_stable", int'(LOCK_STABLE), 1);
        SOFT_RESET_N = 1'b1;
        wait_frn(30, n);
        chk("soft_release_edge", n, 6);

        // Sticky clear, clear coincident with loss, saturation
        CLR_STICKY = 1'b1;
        cyc();
        CLR_STICKY = 1'b0;
        chk("clr_lost", int'(LOCK_LOST), 0);
        CCC_LOCK = 1'b0;
        repeat (5) cyc();
        CLR_STICKY = 1'b1;
        cyc();
        CLR_STICKY = 1'b0;
        chk("clr_vs_set_lost", int'(LOCK_LOST), 1);
        chk("clr_vs_set_count", int'(LOSS_COUNT), 2);
        for (int k = 0; k < 300; k++) begin
            CCC_LOCK = 1'b1;
            wait_frn(40, n);
            if (n < 0) chk("sat_relock_timeout", n, 15);
            CCC_LOCK = 1'b0;
            repeat (6) cyc();
        end
        chk("sat_count", int'(LOSS_COUNT), 255);

        // Asynchronous reset in the middle of HOLD
        CCC_LOCK = 1'b1;
        n = -1;
        for (int e = 1; e <= 40; e++) begin
            cyc();
            if (m_ph == P_HOLD) begin n = e; break; end
        end
        chk("reach_hold", int'(n > 0), 1);
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        chk("async_frn", int'(FABRIC_RESET_N), 0);
        chk("async_stable", int'(LOCK_STABLE), 0);
        chk("async_lost", int'(LOCK_LOST), 0);
        chk("async_count", int'(LOSS_COUNT), 0);
        #1 RESET_N = 1'b1;
        wait_frn(40, n);
        chk("async_release_edge", n, 15);

        // Randomized lock, soft-reset and clear traffic
        for (int s = 0; s < 200; s++) begin
            CCC_LOCK = ($urandom_range(0, 3) != 0);
            SOFT_RESET_N = ($urandom_range(0, 5) != 0);
            len = CCC_LOCK ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 7));
            repeat (len) begin
                CLR_STICKY = ($urandom_range(0, 15) == 0);
                cyc();
            end
            CLR_STICKY = 1'b0;
            if (s % 50 == 49) begin
                #2 RESET_N = 1'b0;
                model_reset();
                #1 RESET_N = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
